// File: rtl/dc_cfg_pkg.sv
// Shared types and constants for the DC DAC configuration sequencer.
package dc_cfg_pkg;

    typedef enum logic [1:0] {
        ST_HDR         = 2'd0,
        ST_DC_LOAD     = 2'd1,
        ST_LAUNCH_LOAD = 2'd2,
        ST_LAUNCH_WAIT = 2'd3
    } state_e;

    localparam logic [31:0] LAUNCH_HDR  = 32'hFFFF_FFFF;
    localparam int          CH_HDR_BASE = 8;
    localparam int          LAUNCH_REGS = 4;

    // Channel header: launch header with the channel's bit above CH_HDR_BASE cleared.
    function automatic logic [31:0] ch_hdr(input int ch);
        return LAUNCH_HDR ^ (32'd1 << (CH_HDR_BASE + ch));
    endfunction

endpackage

// File: rtl/dc_cfg_sequencer_if.sv
// Received-byte stream: master drives bytes, slave consumes them.
interface dc_cfg_sequencer_if;
    logic [7:0] rx_data;
    logic       rx_valid;

    modport master (output rx_data, output rx_valid);
    modport slave  (input  rx_data, input  rx_valid);
endinterface

// File: rtl/dc_byte_packer.sv
// Assembles UART bytes MSB-first into 32-bit words; word_valid_o is combinational on the 4th byte.
module dc_byte_packer (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clear_i,
    dc_cfg_sequencer_if.slave         rx,
    output logic                      word_valid_o,
    output logic [31:0]               word_o,
    output logic [1:0]                byte_cnt_o
);

    logic [1:0]  cnt_q, cnt_d;
    logic [23:0] shift_q, shift_d;

    // Byte counter and shift register next state; clear wins over a new byte.
    always_comb begin
        cnt_d   = cnt_q;
        shift_d = shift_q;
        if (clear_i) begin
            cnt_d = 2'd0;
        end else if (rx.rx_valid) begin
            cnt_d   = cnt_q + 2'd1;
            shift_d = {shift_q[15:0], rx.rx_data};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Packer state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= 2'd0;
            shift_q <= 24'd0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

    assign word_valid_o = rx.rx_valid && !clear_i && (cnt_q == 2'd3);
    assign word_o       = {shift_q, rx.rx_data};
    assign byte_cnt_o   = cnt_q;

endmodule

// File: rtl/dc_cfg_sequencer.sv
// UART-fed configuration sequencer: decodes headers, streams DC register writes, gates launches.
// Optional inter-byte timeout is built when DC_SEQ_TIMEOUT_EN is defined.
module dc_cfg_sequencer #(
    parameter int NUM_CHANNEL    = 4,
    parameter int STREAM_DEPTH   = 2,
    parameter int LAUNCH_REGS    = dc_cfg_pkg::LAUNCH_REGS,
    parameter int TIMEOUT_CYCLES = 100000,
    localparam int TOTAL_REGS    = STREAM_DEPTH * 3 + 2,
    localparam int AW            = $clog2(TOTAL_REGS)
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [7:0]             i_rx_data,
    input  logic                   i_rx_valid,
    input  logic [NUM_CHANNEL-1:0] i_ch_idle,
    output logic                   o_wr_en,
    output logic [NUM_CHANNEL-1:0] o_wr_ch,
    output logic [AW-1:0]          o_wr_addr,
    output logic [31:0]            o_wr_data,
    output logic                   o_launch,
    output logic [NUM_CHANNEL-1:0] o_launch_mask,
    output logic [95:0]            o_launch_args,
    output logic                   o_busy,
    output logic                   o_err
);
    import dc_cfg_pkg::*;

    dc_cfg_sequencer_if rx_if ();
    assign rx_if.rx_data  = i_rx_data;
    assign rx_if.rx_valid = i_rx_valid;

    state_e                 state_q, state_d;
    logic [NUM_CHANNEL-1:0] ch_q, ch_d, wr_ch_d, mask_d, hit_oh_s;
    logic [AW-1:0]          idx_q, idx_d, wr_addr_d;
    logic [7:0]             lidx_q, lidx_d;
    logic [31:0]            wr_data_d, word_s;
    logic [95:0]            args_d;
    logic                   wr_en_d, launch_d, err_d, busy_d, word_valid_s, hit_s, tmo_fire_s, clear_s;
    logic [1:0]             byte_cnt_s;

    // Bytes are dropped while a launch is pending, and a timeout abandons the partial word.
    assign clear_s = (state_q == ST_LAUNCH_WAIT) || tmo_fire_s;

    dc_byte_packer u_packer (
        .clk          (i_clk),
        .rst_n        (i_rst_n),
        .clear_i      (clear_s),
        .rx           (rx_if.slave),
        .word_valid_o (word_valid_s),
        .word_o       (word_s),
        .byte_cnt_o   (byte_cnt_s)
    );

    // Channel header decode into a one-hot target.
    always_comb begin
        hit_s    = 1'b0;
        hit_oh_s = '0;
        for (int i = 0; i < NUM_CHANNEL; i++) begin
            if (word_s == ch_hdr(i)) begin
                hit_s       = 1'b1;
                hit_oh_s[i] = 1'b1;
            end else begin
                hit_oh_s[i] = 1'b0;
            end
        end
    end

`ifdef DC_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_q, tmo_d;
    logic          tmo_active_s;

    // Silence counter; restarts on every byte and only runs mid-frame outside LAUNCH_WAIT.
    always_comb begin
        tmo_active_s = ((state_q == ST_HDR) && (byte_cnt_s != 2'd0)) ||
                       (state_q == ST_DC_LOAD) || (state_q == ST_LAUNCH_LOAD);
        tmo_fire_s   = 1'b0;
        tmo_d        = '0;
        if (i_rx_valid || !tmo_active_s) begin
            tmo_d = '0;
        end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
            tmo_fire_s = 1'b1;
        end else begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    // Timeout counter register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) tmo_q <= '0;
        else          tmo_q <= tmo_d;
    end
`else
    logic unused_s;
    assign tmo_fire_s = 1'b0;
    assign unused_s   = ^{1'b0, byte_cnt_s, TIMEOUT_CYCLES[0]};
`endif

    // Sequencer next state and next registered outputs.
    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        idx_d     = idx_q;
        lidx_d    = lidx_q;
        wr_en_d   = 1'b0;
        wr_ch_d   = o_wr_ch;
        wr_addr_d = o_wr_addr;
        wr_data_d = o_wr_data;
        launch_d  = 1'b0;
        mask_d    = o_launch_mask;
        args_d    = o_launch_args;
        err_d     = 1'b0;
        case (state_q)
            ST_HDR: begin
                if (!word_valid_s) begin
                    state_d = ST_HDR;
                end else if (word_s == LAUNCH_HDR) begin
                    state_d = ST_LAUNCH_LOAD;
                    lidx_d  = 8'd0;
                end else if (hit_s) begin
                    state_d = ST_DC_LOAD;
                    ch_d    = hit_oh_s;
                    idx_d   = '0;
                end else begin
                    err_d = 1'b1;
                end
            end
            ST_DC_LOAD: begin
                if (word_valid_s) begin
                    wr_en_d   = 1'b1;
                    wr_ch_d   = ch_q;
                    wr_addr_d = idx_q;
                    wr_data_d = word_s;
                    if (idx_q == AW'(TOTAL_REGS - 1)) begin
                        state_d = ST_HDR;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    state_d = ST_DC_LOAD;
                end
            end
            ST_LAUNCH_LOAD: begin
                if (word_valid_s) begin
                    case (lidx_q)
                        8'd0:    mask_d          = word_s[NUM_CHANNEL-1:0];
                        8'd1:    args_d[95:64]   = word_s;
                        8'd2:    args_d[63:32]   = word_s;
                        8'd3:    args_d[31:0]    = word_s;
                        default: args_d          = o_launch_args;
                    endcase
                    if (lidx_q == 8'(LAUNCH_REGS - 1)) begin
                        lidx_d = 8'd0;
                        if (mask_d == '0) begin
                            err_d   = 1'b1;
                            state_d = ST_HDR;
                        end else begin
                            state_d = ST_LAUNCH_WAIT;
                        end
                    end else begin
                        lidx_d = lidx_q + 8'd1;
                    end
                end else begin
                    state_d = ST_LAUNCH_LOAD;
                end
            end
            ST_LAUNCH_WAIT: begin
                err_d = i_rx_valid;
                if ((i_ch_idle & o_launch_mask) == o_launch_mask) begin
                    launch_d = 1'b1;
                    state_d  = ST_HDR;
                end else begin
                    state_d = ST_LAUNCH_WAIT;
                end
            end
            default: state_d = ST_HDR;
        endcase
        if (tmo_fire_s) begin
            err_d   = 1'b1;
            state_d = ST_HDR;
            idx_d   = '0;
            lidx_d  = 8'd0;
        end else begin
            err_d = err_d;
        end
        busy_d = (state_d != ST_HDR);
    end

    // State and output registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q       <= ST_HDR;
            ch_q          <= '0;
            idx_q         <= '0;
            lidx_q        <= 8'd0;
            o_wr_en       <= 1'b0;
            o_wr_ch       <= '0;
            o_wr_addr     <= '0;
            o_wr_data     <= 32'd0;
            o_launch      <= 1'b0;
            o_launch_mask <= '0;
            o_launch_args <= 96'd0;
            o_busy        <= 1'b0;
            o_err         <= 1'b0;
        end else begin
            state_q       <= state_d;
            ch_q          <= ch_d;
            idx_q         <= idx_d;
            lidx_q        <= lidx_d;
            o_wr_en       <= wr_en_d;
            o_wr_ch       <= wr_ch_d;
            o_wr_addr     <= wr_addr_d;
            o_wr_data     <= wr_data_d;
            o_launch      <= launch_d;
            o_launch_mask <= mask_d;
            o_launch_args <= args_d;
            o_busy        <= busy_d;
            o_err         <= err_d;
        end
    end

endmodule

// File: doc/dc_cfg_sequencer.md
DC_CFG_SEQUENCER -- requirements
Module: dc_cfg_sequencer

Interface
REQ-001 SHALL have parameter NUM_CHANNEL, default 4: number of DC DAC channels.
REQ-002 SHALL have parameter STREAM_DEPTH, default 2: per-channel stream depth; localparam TOTAL_REGS = STREAM_DEPTH*3+2.
REQ-003 SHALL have parameter LAUNCH_REGS, default 4: words in a launch frame.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 100000: inter-byte timeout, in clocks.
REQ-005 Ports:
- i_clk  in  1  sole clock.
- i_rst_n  in  1  reset, synchronous, active-low.
- i_rx_data  in  8  received UART byte.
- i_rx_valid  in  1  one-cycle strobe; i_rx_data valid.
- i_ch_idle  in  NUM_CHANNEL  per-channel core idle and FIFO empty.
- o_wr_en  out  1  register-write strobe.
- o_wr_ch  out  NUM_CHANNEL  one-hot target channel.
- o_wr_addr  out  $clog2(TOTAL_REGS)  register index.
- o_wr_data  out  32  register word.
- o_launch  out  1  one-cycle launch pulse.
- o_launch_mask  out  NUM_CHANNEL  channels to launch.
- o_launch_args  out  96  launch words 1..3, word1 in [95:64].
- o_busy  out  1  high whenever state is not HDR.
- o_err  out  1  one-cycle error pulse.

Function
REQ-006 SHALL assemble bytes MSB-first into 32-bit words; a word completes on the 4th i_rx_valid.
REQ-007 SHALL implement states HDR, DC_LOAD, LAUNCH_LOAD, LAUNCH_WAIT.
REQ-008 In HDR, word 0xFFFF_FFFF SHALL go to LAUNCH_LOAD.
REQ-009 In HDR, a word equal to 0xFFFF_FFFF ^ (1<<(8+i)), i < NUM_CHANNEL, SHALL latch channel i and go to DC_LOAD.
REQ-010 In HDR, any other word SHALL pulse o_err, stay in HDR and clear the byte counter (word-aligned resync).
REQ-011 In DC_LOAD, each completed word SHALL produce o_wr_en for exactly one cycle, on the clock after the 4th byte's strobe.
- Same cycle: o_wr_ch = latched one-hot, o_wr_addr = 0..TOTAL_REGS-1 in order, o_wr_data = the word.
- After index TOTAL_REGS-1, return to HDR.
REQ-012 In LAUNCH_LOAD:
- Word 0 bits [NUM_CHANNEL-1:0] SHALL be latched into o_launch_mask.
- Words 1..3 SHALL be latched into o_launch_args.
- After word LAUNCH_REGS-1: mask == 0 pulses o_err and returns to HDR; otherwise go to LAUNCH_WAIT.
REQ-013 In LAUNCH_WAIT:
- Wait until (i_ch_idle & mask) == mask, then pulse o_launch for one cycle and return to HDR in the same clock.
- If the condition is true on entry, o_launch fires on the first LAUNCH_WAIT cycle.
REQ-014 Bytes arriving in LAUNCH_WAIT SHALL be discarded, each with an o_err pulse; the byte counter stays 0.
REQ-015 o_launch_mask and o_launch_args SHALL hold their values until the next launch frame overwrites them.
REQ-016 o_wr_en and o_launch SHALL never be asserted in the same cycle.

Reset
REQ-017 On the clock where i_rst_n = 0:
- state SHALL become HDR and the byte counter 0.
- o_wr_en, o_launch and o_err SHALL be 0.
- o_wr_ch, o_wr_addr, o_wr_data, o_launch_mask and o_launch_args SHALL be 0.
- o_busy SHALL be 0.
REQ-018 Reset mid-frame SHALL abandon the partial frame with no write and no launch.

Configuration
REQ-019 Macro DC_SEQ_TIMEOUT_EN:
- Defined: in HDR with a partial word, or in DC_LOAD or LAUNCH_LOAD, TIMEOUT_CYCLES clocks with no i_rx_valid SHALL pulse o_err, clear the byte counter and return to HDR. The counter restarts on every byte and never applies in LAUNCH_WAIT.
- Undefined: no timeout counter is built; the block waits indefinitely.

Structure
REQ-020 Shared package dc_cfg_pkg SHALL hold:
- the state enum;
- LAUNCH_HDR = 32'hFFFF_FFFF;
- CH_HDR_BASE bit offset = 8;
- LAUNCH_REGS.
REQ-021 Sub-module dc_byte_packer SHALL perform byte-to-word assembly, with a clear input and word-valid output.

Verification
REQ-022 Header 0xFFFF_FEFF followed by 8 words 0x0000_0001..0x0000_0008:
- 8 o_wr_en pulses, o_wr_ch = 4'b0001, addr 0..7, matching data;
- o_busy low afterward.
REQ-023 Header 0xFFFF_F7FF followed by 8 words: all writes carry o_wr_ch = 4'b1000.
REQ-024 Launch header, then words 0x0000_0005, 0xA, 0xB, 0xC, with i_ch_idle = 4'b0001:
- no o_launch while waiting;
- after i_ch_idle goes to 4'b0101, o_launch fires once with mask 4'b0101 and args {A,B,C}.
REQ-025 Header 0x1234_5678: o_err pulse; state HDR. A valid header sent next is accepted normally.
REQ-026 Launch frame with word0 = 0: o_err pulse, no o_launch, return to HDR.
REQ-027 With DC_SEQ_TIMEOUT_EN, 2 bytes then silence for TIMEOUT_CYCLES: o_err pulse, byte counter 0. A following full header is decoded correctly.
